// File: rtl/sys_result_drain.sv
// Result drain: captures skewed column results into per-column FIFOs and writes them row-major to SRAM.
// Optional build macro WB_RELU_EN clamps negative words to zero in the write stage.
module sys_result_drain #(
  parameter int DATAWIDTH  = 16,
  parameter int ARRAY_SIZE = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ARRAY_SIZE-1:0]            result_valid,
  input  logic [ARRAY_SIZE*DATAWIDTH-1:0]  result_in,
  output logic [ARRAY_SIZE-1:0]            col_full,
  input  logic                             wb_start,
  input  logic [ADDR_WIDTH-1:0]            wb_addr,
  output logic                             sram_we,
  output logic [ADDR_WIDTH-1:0]            sram_waddr,
  output logic [DATAWIDTH-1:0]             sram_wdata,
  output logic                             wb_busy,
  output logic                             wb_done,
  output logic                             overflow
);

  localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int IDXW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ARRAY_SIZE - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [DATAWIDTH-1:0]  mem_q   [ARRAY_SIZE][FIFO_DEPTH];
  logic [PTRW-1:0]       wrPtr_q [ARRAY_SIZE];
  logic [PTRW-1:0]       wrPtr_d [ARRAY_SIZE];
  logic [PTRW-1:0]       rdPtr_q [ARRAY_SIZE];
  logic [PTRW-1:0]       rdPtr_d [ARRAY_SIZE];
  logic [CNTW-1:0]       cnt_q   [ARRAY_SIZE];
  logic [CNTW-1:0]       cnt_d   [ARRAY_SIZE];

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [IDXW-1:0]       row_q, row_d;
  logic [IDXW-1:0]       col_q, col_d;
  logic                  overflow_q, overflow_d;
  logic                  sramWe_q;
  logic [ADDR_WIDTH-1:0] sramWaddr_q, sramWaddr_d;
  logic [DATAWIDTH-1:0]  sramWdata_q, sramWdata_d;

  logic                  pop;
  logic [DATAWIDTH-1:0]  popWord;
  logic [ARRAY_SIZE-1:0] popCol, pushOk, dropCol;

  always_comb begin
    for (int c = 0; c < ARRAY_SIZE; c++) begin
      col_full[c] = (cnt_q[c] == CNTW'(FIFO_DEPTH));
    end
  end

  // The drain only ever pops the column it is waiting on, so a stalled column blocks the tile.
  assign pop     = (state_q == ST_DRAIN) && (cnt_q[col_q] != '0);
  assign popWord = mem_q[col_q][rdPtr_q[col_q]];

  always_comb begin
    popCol  = '0;
    pushOk  = '0;
    dropCol = '0;
    for (int c = 0; c < ARRAY_SIZE; c++) begin
      popCol[c]  = pop && (col_q == IDXW'(c));
      pushOk[c]  = result_valid[c] && (!col_full[c] || popCol[c]);
      dropCol[c] = result_valid[c] && col_full[c] && !popCol[c];
      wrPtr_d[c] = pushOk[c] ? wrPtr_q[c] + PTRW'(1) : wrPtr_q[c];
      rdPtr_d[c] = popCol[c] ? rdPtr_q[c] + PTRW'(1) : rdPtr_q[c];
      cnt_d[c]   = cnt_q[c] + CNTW'(pushOk[c]) - CNTW'(popCol[c]);
    end
    overflow_d = overflow_q | (|dropCol);
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < ARRAY_SIZE; c++) begin
      if (pushOk[c]) begin
        mem_q[c][wrPtr_q[c]] <= result_in[c*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      ST_IDLE: begin
        if (wb_start) begin
          base_d  = wb_addr;
          row_d   = '0;
          col_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop) begin
          if (col_q == LAST_IDX) begin
            col_d = '0;
            if (row_q == LAST_IDX) begin
              row_d   = '0;
              state_d = ST_DONE;
            end else begin
              row_d = row_q + IDXW'(1);
            end
          end else begin
            col_d = col_q + IDXW'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign sramWaddr_d = base_q + ADDR_WIDTH'(row_q) * ADDR_WIDTH'(ARRAY_SIZE) + ADDR_WIDTH'(col_q);
`ifdef WB_RELU_EN
  assign sramWdata_d = popWord[DATAWIDTH-1] ? '0 : popWord;
`else
  assign sramWdata_d = popWord;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < ARRAY_SIZE; c++) begin
        wrPtr_q[c] <= '0;
        rdPtr_q[c] <= '0;
        cnt_q[c]   <= '0;
      end
      state_q     <= ST_IDLE;
      base_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      overflow_q  <= 1'b0;
      sramWe_q    <= 1'b0;
      sramWaddr_q <= '0;
      sramWdata_q <= '0;
    end else begin
      for (int c = 0; c < ARRAY_SIZE; c++) begin
        wrPtr_q[c] <= wrPtr_d[c];
        rdPtr_q[c] <= rdPtr_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      state_q    <= state_d;
      base_q     <= base_d;
      row_q      <= row_d;
      col_q      <= col_d;
      overflow_q <= overflow_d;
      sramWe_q   <= pop;
      if (pop) begin
        sramWaddr_q <= sramWaddr_d;
        sramWdata_q <= sramWdata_d;
      end
    end
  end

  assign sram_we    = sramWe_q;
  assign sram_waddr = sramWaddr_q;
  assign sram_wdata = sramWdata_q;
  assign wb_busy    = (state_q == ST_DRAIN);
  assign wb_done    = (state_q == ST_DONE);
  assign overflow   = overflow_q;

endmodule
